dm_lsu: RTL and testbench
=========================

Name: dm_lsu

Overview:
Parametrised load/store unit between the CPU memory stage and a synchronous, byte-enabled data RAM with configurable read latency.
- Accepts one request at a time over a valid/ready handshake.
- Generates lane enables and replicated write data.
- Waits out the RAM read latency, then extracts and sign/zero-extends load data.
- Flags misaligned or illegal accesses instead of touching memory.
- Generalises the combinational data-memory controller to XLEN 32/64, multi-cycle RAM and a response handshake.

Parameters:
XLEN, 32, datapath width; 32 or 64 only.
ADDR_W, 32, byte-address width.
MEM_LAT, 1, RAM read latency in cycles, from mem_en to valid mem_rdata; legal range 1..4.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  unit can accept a request
req_we  in  1  1=store, 0=load
req_ctrl  in  3  access size/sign, encodings in Behaviour
req_addr  in  ADDR_W  byte address
req_wdata  in  XLEN  store data, right-aligned
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_rdata  out  XLEN  extended load data; 0 for stores and errors
rsp_err  out  1  misaligned or illegal access
mem_en  out  1  RAM access strobe, one cycle
mem_we  out  XLEN/8  per-byte write enables
mem_addr  out  ADDR_W  lane-aligned address (low log2(XLEN/8) bits zero)
mem_wdata  out  XLEN  lane-replicated write data
mem_rdata  in  XLEN  RAM read data

Behaviour:
- Shared ctrl encodings:
  - 000 word, 001 half, 010 half unsigned, 011 byte, 100 byte unsigned.
  - 101 word unsigned and 110 doubleword: XLEN=64 only.
  - Any other code, or 101/110 with XLEN=32, is illegal.
- Alignment: half needs addr[0]=0; word needs addr[1:0]=0; dword needs addr[2:0]=0.
- States: IDLE, RD_WAIT, RESP. req_ready=1 only in IDLE.
- IDLE, handshake fires (req_valid & req_ready):
  - Request latched: addr, ctrl, we.
  - Error (misaligned or illegal): no mem_en, no mem_we; go RESP with rsp_err=1, rsp_rdata=0.
  - Store: mem_en=1 and mem_we=lane mask in the same cycle. mem_wdata = byte×(XLEN/8), half×(XLEN/16), word×(XLEN/32) or full data. Go RESP with rsp_err=0, rsp_rdata=0.
  - Load: mem_en=1, mem_we=0; latency counter loaded with MEM_LAT-1; go RD_WAIT.
- RD_WAIT:
  - Counter decrements each cycle.
  - Capture happens MEM_LAT cycles after mem_en: mem_rdata is sampled, the lane selected by the latched addr low bits, sign/zero-extended to XLEN, and registered into rsp_rdata. Go RESP.
  - With MEM_LAT=1, capture occurs on the first RD_WAIT cycle.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err held stable until rsp_ready.
  - On rsp_valid & rsp_ready go to IDLE. The next request cannot be accepted in that same cycle.
  - Throughput: 2 cycles per store, MEM_LAT+2 cycles per load with rsp_ready tied high.
- mem_en and mem_we are asserted for exactly one cycle per access and are 0 in every other cycle.
- Reset:
  - Outputs: state IDLE; req_ready=1 the cycle after reset; rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - Reset mid-load abandons the access; late mem_rdata is ignored.
- rsp_ready high while rsp_valid=0 has no effect.
- req inputs are ignored while req_ready=0.

Decomposition:
- Package dm_pkg holds:
  - ctrl encoding localparams (DM_WORD … DM_DWORD);
  - state enum;
  - function lane_mask(ctrl, addr_lo);
  - function is_misaligned(ctrl, addr_lo).
- Sub-module dm_load_align (combinational): extracts the lane from mem_rdata and sign/zero-extends it. Inputs: rdata, ctrl, addr_lo. Output: XLEN result.
- FSM, counter and store replication stay in dm_lsu.

Test Plan:
1. XLEN=32, MEM_LAT=1:
   - Store byte 0xA5 at addr 0x0000_0003 → mem_we=1000, mem_wdata=0xA5A5A5A5.
   - rsp_valid next cycle, rsp_err=0.
2. XLEN=32, MEM_LAT=3, mem_rdata=0x8001_7F80:
   - Load half at 0x2 → rsp_rdata=0xFFFF_8001.
   - Load half unsigned at 0x2 → 0x0000_8001.
   - Load byte at 0x0 → 0xFFFF_FF80.
   - rsp_valid 4 cycles after the handshake.
3. Misaligned word load at 0x0000_0006 → mem_en never asserts, rsp_err=1, rsp_rdata=0.
   - Also, ctrl=110 with XLEN=32 → rsp_err=1.
4. XLEN=64:
   - Dword store 0x0123_4567_89AB_CDEF at 0x8 → mem_we=0xFF.
   - Word-unsigned load at 0x4 with mem_rdata=0x8000_0000_0000_0000 → rsp_rdata=0x0000_0000_8000_0000.
5. Backpressure: rsp_ready held 0 for 5 cycles → rsp_valid and data stable, req_ready=0, and a new req_valid is ignored until acceptance.
6. Assert rst during RD_WAIT → next cycle state IDLE, rsp_valid=0; no stale response after mem_rdata returns.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory load/store unit: access-size encodings,
// FSM states and the lane/alignment helpers used on the request path.
package dm_pkg;

   localparam logic [2:0] DM_WORD  = 3'b000;
   localparam logic [2:0] DM_HALF  = 3'b001;
   localparam logic [2:0] DM_HALFU = 3'b010;
   localparam logic [2:0] DM_BYTE  = 3'b011;
   localparam logic [2:0] DM_BYTEU = 3'b100;
   localparam logic [2:0] DM_WORDU = 3'b101;
   localparam logic [2:0] DM_DWORD = 3'b110;

   typedef enum logic [1:0] {
      IDLE,
      RD_WAIT,
      RESP
   } dm_state_e;

   // Mask is computed for an 8-lane bus; narrower buses keep only the low lanes.
   function automatic logic [7:0] lane_mask(input logic [2:0] ctrl, input logic [2:0] addr_lo);
      logic [7:0] m;
      case (ctrl)
         DM_BYTE, DM_BYTEU: m = 8'h01;
         DM_HALF, DM_HALFU: m = 8'h03;
         DM_WORD, DM_WORDU: m = 8'h0F;
         DM_DWORD:          m = 8'hFF;
         default:           m = 8'h00;
      endcase
      return m << addr_lo;
   endfunction

   function automatic logic is_misaligned(input logic [2:0] ctrl, input logic [2:0] addr_lo);
      logic mis;
      case (ctrl)
         DM_HALF, DM_HALFU: mis = addr_lo[0];
         DM_WORD, DM_WORDU: mis = (addr_lo[1:0] != 2'b00);
         DM_DWORD:          mis = (addr_lo != 3'b000);
         default:           mis = 1'b0;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/dm_load_align.sv
// Picks the addressed lane out of a RAM read word and sign/zero-extends it to the
// full datapath width.
module dm_load_align
   import dm_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] rdata,
   input  logic [2:0]      ctrl,
   input  logic [2:0]      addr_lo,
   output logic [XLEN-1:0] result
);

   logic [XLEN-1:0] shifted;

   // Size casts of signed slices give sign extension; unsigned slices zero-fill.
   always_comb begin
      shifted = rdata >> {addr_lo, 3'b000};
      case (ctrl)
         DM_BYTE:  result = XLEN'($signed(shifted[7:0]));
         DM_BYTEU: result = XLEN'(shifted[7:0]);
         DM_HALF:  result = XLEN'($signed(shifted[15:0]));
         DM_HALFU: result = XLEN'(shifted[15:0]);
         DM_WORD:  result = XLEN'($signed(shifted[31:0]));
         DM_WORDU: result = XLEN'(shifted[31:0]);
         default:  result = shifted;
      endcase
   end

endmodule

// File: rtl/dm_lsu.sv
// Load/store unit: one request at a time, drives a byte-enabled RAM with fixed read
// latency and returns extended load data or an error flag over a response handshake.
module dm_lsu
   import dm_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int ADDR_W  = 32,
   parameter int MEM_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_ctrl,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [XLEN-1:0]   req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [XLEN-1:0]   rsp_rdata,
   output logic              rsp_err,
   output logic              mem_en,
   output logic [XLEN/8-1:0] mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [XLEN-1:0]   mem_wdata,
   input  logic [XLEN-1:0]   mem_rdata
);

   localparam int NB   = XLEN / 8;
   localparam int LO_W = $clog2(NB);

   dm_state_e       state_q, state_d;
   logic [2:0]      ctrl_q, addrLo_q, addrLo;
   logic [1:0]      cnt_q;
   logic [XLEN-1:0] rdata_q, loadData, storeData;
   logic            err_q, reqErr, illegal, fire;

   always_comb begin
      addrLo = '0;
      addrLo[LO_W-1:0] = req_addr[LO_W-1:0];
      illegal = (req_ctrl > DM_DWORD);
      if (XLEN == 32 && (req_ctrl == DM_WORDU || req_ctrl == DM_DWORD)) begin
         illegal = 1'b1;
      end
      reqErr = illegal | is_misaligned(req_ctrl, addrLo);
      fire   = req_valid & req_ready;
   end

   always_comb begin
      case (req_ctrl)
         DM_BYTE, DM_BYTEU: storeData = {NB{req_wdata[7:0]}};
         DM_HALF, DM_HALFU: storeData = {(XLEN/16){req_wdata[15:0]}};
         DM_WORD, DM_WORDU: storeData = {(XLEN/32){req_wdata[31:0]}};
         default:           storeData = req_wdata;
      endcase
   end

   dm_load_align #(.XLEN(XLEN)) u_align (
      .rdata   (mem_rdata),
      .ctrl    (ctrl_q),
      .addr_lo (addrLo_q),
      .result  (loadData)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (fire) state_d = (reqErr || req_we) ? RESP : RD_WAIT;
         RD_WAIT: if (cnt_q == 2'd0) state_d = RESP;
         RESP:    if (rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // The RAM strobe is combinational so the access starts in the handshake cycle.
   always_comb begin
      req_ready = (state_q == IDLE);
      rsp_valid = (state_q == RESP);
      mem_en    = 1'b0;
      mem_we    = '0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (req_valid && state_q == IDLE && !reqErr) begin
         mem_en   = 1'b1;
         mem_addr = {req_addr[ADDR_W-1:LO_W], {LO_W{1'b0}}};
         if (req_we) begin
            mem_we    = NB'(lane_mask(req_ctrl, addrLo));
            mem_wdata = storeData;
         end
      end
   end

   // Read data is only sampled on the cycle the counter hits zero, so data returning
   // after a reset (state already IDLE) never reaches the response register.
   always_ff @(posedge clk) begin
      if (rst) begin
         ctrl_q   <= '0;
         addrLo_q <= '0;
         cnt_q    <= '0;
         err_q    <= 1'b0;
         rdata_q  <= '0;
      end else if (fire) begin
         ctrl_q   <= req_ctrl;
         addrLo_q <= addrLo;
         cnt_q    <= 2'(MEM_LAT - 1);
         err_q    <= reqErr;
         rdata_q  <= '0;
      end else if (state_q == RD_WAIT) begin
         if (cnt_q == 2'd0) begin
            rdata_q <= loadData;
         end else begin
            cnt_q <= cnt_q - 2'd1;
         end
      end
   end

   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;

endmodule

// File: tb/tb_dm_lsu.sv
// Randomised scoreboard bench for dm_lsu: a 32-bit/latency-3 and a 64-bit/latency-1
// instance are driven in turn against a byte-level reference model.
module tb_dm_lsu;

   typedef struct {
      logic        err;
      logic [7:0]  memWe;
      logic [31:0] memAddr;
      logic [63:0] memWdata;
      logic [63:0] rdata;
   } exp_t;

   typedef struct {
      logic [63:0] rdata;
      logic        err;
      int          due;
   } rsp_t;

   typedef struct {
      logic [7:0]  we;
      logic [31:0] addr;
      logic [63:0] wdata;
      logic        isStore;
   } mem_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        reqValid[2], reqWe[2], rspReady[2];
   logic [2:0]  reqCtrl[2];
   logic [31:0] reqAddr[2];
   logic [63:0] reqWdata[2], memRdata[2];

   logic        reqReady[2], rspValid[2], rspErr[2], memEn[2];
   logic [63:0] rspRdata[2], memWdata[2];
   logic [7:0]  memWe[2];
   logic [31:0] memAddr[2];

   logic        reqReady0, rspValid0, rspErr0, memEn0;
   logic        reqReady1, rspValid1, rspErr1, memEn1;
   logic [31:0] rspRdata0, memWdata0, memAddr0, memAddr1;
   logic [63:0] rspRdata1, memWdata1;
   logic [3:0]  memWe0;
   logic [7:0]  memWe1;

   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   bit   busy[2];
   rsp_t rspQ[2][$];
   mem_t memQ[2][$];
   logic [63:0] ramWord[2];
   int   holdCnt[2];
   int   dueCnt[2];
   bit   enSeen[2];

   dm_lsu #(.XLEN(32), .ADDR_W(32), .MEM_LAT(3)) dut0 (
      .clk(clk), .rst(rst),
      .req_valid(reqValid[0]), .req_ready(reqReady0), .req_we(reqWe[0]),
      .req_ctrl(reqCtrl[0]), .req_addr(reqAddr[0]), .req_wdata(reqWdata[0][31:0]),
      .rsp_valid(rspValid0), .rsp_ready(rspReady[0]), .rsp_rdata(rspRdata0), .rsp_err(rspErr0),
      .mem_en(memEn0), .mem_we(memWe0), .mem_addr(memAddr0), .mem_wdata(memWdata0),
      .mem_rdata(memRdata[0][31:0])
   );

   dm_lsu #(.XLEN(64), .ADDR_W(32), .MEM_LAT(1)) dut1 (
      .clk(clk), .rst(rst),
      .req_valid(reqValid[1]), .req_ready(reqReady1), .req_we(reqWe[1]),
      .req_ctrl(reqCtrl[1]), .req_addr(reqAddr[1]), .req_wdata(reqWdata[1]),
      .rsp_valid(rspValid1), .rsp_ready(rspReady[1]), .rsp_rdata(rspRdata1), .rsp_err(rspErr1),
      .mem_en(memEn1), .mem_we(memWe1), .mem_addr(memAddr1), .mem_wdata(memWdata1),
      .mem_rdata(memRdata[1])
   );

   assign reqReady[0] = reqReady0;
   assign reqReady[1] = reqReady1;
   assign rspValid[0] = rspValid0;
   assign rspValid[1] = rspValid1;
   assign rspErr[0]   = rspErr0;
   assign rspErr[1]   = rspErr1;
   assign memEn[0]    = memEn0;
   assign memEn[1]    = memEn1;
   assign rspRdata[0] = {32'h0, rspRdata0};
   assign rspRdata[1] = rspRdata1;
   assign memWdata[0] = {32'h0, memWdata0};
   assign memWdata[1] = memWdata1;
   assign memWe[0]    = {4'h0, memWe0};
   assign memWe[1]    = memWe1;
   assign memAddr[0]  = memAddr0;
   assign memAddr[1]  = memAddr1;

   function automatic int latOf(int d);
      return (d == 0) ? 3 : 1;
   endfunction

   function automatic int xlOf(int d);
      return (d == 0) ? 32 : 64;
   endfunction

   // Byte-level reference: size/sign from the access code, lanes from address modulo bus width.
   function automatic exp_t model(int xl, logic we, logic [2:0] ctrl, logic [31:0] addr,
                                  logic [63:0] wdata, logic [63:0] ram);
      exp_t e;
      int size, nb, off;
      bit sgn, legal;
      logic [63:0] val;
      e.err = 1'b0; e.memWe = '0; e.memAddr = '0; e.memWdata = '0; e.rdata = '0;
      nb = xl / 8;
      legal = 1'b1;
      sgn = 1'b0;
      case (ctrl)
         3'd0: begin size = 4; sgn = 1'b1; end
         3'd1: begin size = 2; sgn = 1'b1; end
         3'd2: size = 2;
         3'd3: begin size = 1; sgn = 1'b1; end
         3'd4: size = 1;
         3'd5: begin size = 4; legal = (xl == 64); end
         3'd6: begin size = 8; legal = (xl == 64); end
         default: begin size = 1; legal = 1'b0; end
      endcase
      e.err = !legal || ((int'(addr[2:0]) % size) != 0);
      if (e.err) return e;
      off = int'(addr[2:0]) % nb;
      e.memAddr = addr - 32'(off);
      if (we) begin
         for (int k = 0; k < size; k++) e.memWe[off + k] = 1'b1;
         for (int j = 0; j < nb; j++) e.memWdata[j*8 +: 8] = wdata[(j % size)*8 +: 8];
      end else begin
         val = '0;
         for (int k = 0; k < size; k++) val[k*8 +: 8] = ram[(off + k)*8 +: 8];
         if (sgn && val[size*8 - 1]) begin
            for (int k = size; k < nb; k++) val[k*8 +: 8] = 8'hFF;
         end
         e.rdata = val;
      end
      return e;
   endfunction

   task automatic checkOutput(string name, int d, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s dut%0d actual=0x%0h expected=0x%0h", name, d, act, exp);
      end
   endtask

   task automatic monitor(int d);
      bit   fireNow, expEn, expValid;
      mem_t m;
      if (rst) begin
         busy[d] = 1'b0;
         rspQ[d].delete();
         memQ[d].delete();
         return;
      end
      checkOutput("req_ready", d, 64'(reqReady[d]), 64'(!busy[d]));
      fireNow = reqValid[d] && !busy[d];
      expEn = fireNow && (memQ[d].size() > 0);
      checkOutput("mem_en", d, 64'(memEn[d]), 64'(expEn));
      if (expEn && memEn[d]) begin
         m = memQ[d].pop_front();
         checkOutput("mem_we", d, 64'(memWe[d]), 64'(m.we));
         checkOutput("mem_addr", d, 64'(memAddr[d]), 64'(m.addr));
         if (m.isStore) checkOutput("mem_wdata", d, memWdata[d], m.wdata);
      end else if (!memEn[d]) begin
         checkOutput("mem_we_idle", d, 64'(memWe[d]), 64'h0);
      end
      expValid = busy[d] && (rspQ[d].size() > 0) && (cyc >= rspQ[d][0].due);
      checkOutput("rsp_valid", d, 64'(rspValid[d]), 64'(expValid));
      if (rspValid[d] && expValid) begin
         checkOutput("rsp_rdata", d, rspRdata[d], rspQ[d][0].rdata);
         checkOutput("rsp_err", d, 64'(rspErr[d]), 64'(rspQ[d][0].err));
         if (rspReady[d]) begin
            void'(rspQ[d].pop_front());
            busy[d] = 1'b0;
         end
      end
      if (fireNow) busy[d] = 1'b1;
   endtask

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) monitor(d);
   end

   // RAM: read data is valid only in the cycle MEM_LAT after the strobe, junk otherwise.
   always begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) enSeen[d] = memEn[d] && (memWe[d] == 8'h0);
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         if (dueCnt[d] > 0) dueCnt[d]--;
         if (enSeen[d]) dueCnt[d] = latOf(d);
         memRdata[d] = (dueCnt[d] == 1) ? ramWord[d] : {$urandom, $urandom};
      end
   end

   always @(posedge clk) begin
      #1;
      for (int d = 0; d < 2; d++) begin
         if (holdCnt[d] > 0) begin
            holdCnt[d]--;
            rspReady[d] = 1'b0;
         end else begin
            rspReady[d] = ($urandom % 4) != 0;
         end
      end
   end

   // While a request is outstanding, present junk requests that must be ignored.
   task automatic waitIdle(int d);
      int n = 0;
      while (busy[d] && n < 80) begin
         reqValid[d] = 1'($urandom % 2);
         reqWe[d]    = 1'($urandom % 2);
         reqCtrl[d]  = 3'($urandom);
         reqAddr[d]  = $urandom;
         reqWdata[d] = {$urandom, $urandom};
         @(posedge clk);
         #1;
         n++;
      end
      reqValid[d] = 1'b0;
      checkOutput("idle_wait", d, 64'(busy[d]), 64'h0);
   endtask

   task automatic applyStimulus(int d, logic we, logic [2:0] ctrl, logic [31:0] addr,
                                logic [63:0] wdata, logic [63:0] ram);
      exp_t e;
      rsp_t r;
      mem_t m;
      waitIdle(d);
      e = model(xlOf(d), we, ctrl, addr, wdata, ram);
      ramWord[d] = ram;
      if (!e.err) begin
         m.we = e.memWe; m.addr = e.memAddr; m.wdata = e.memWdata; m.isStore = we;
         memQ[d].push_back(m);
      end
      r.rdata = e.rdata;
      r.err   = e.err;
      r.due   = cyc + ((e.err || we) ? 1 : latOf(d) + 1);
      rspQ[d].push_back(r);
      reqValid[d] = 1'b1;
      reqWe[d]    = we;
      reqCtrl[d]  = ctrl;
      reqAddr[d]  = addr;
      reqWdata[d] = wdata;
      @(posedge clk);
      #1;
      reqValid[d] = 1'b0;
   endtask

   task automatic randomTraffic(int d, int n);
      logic [31:0] addr;
      for (int i = 0; i < n; i++) begin
         addr = $urandom;
         if ($urandom % 3 != 0) addr[2:0] = 3'b000;
         applyStimulus(d, 1'($urandom % 2), 3'($urandom % 8), addr,
                       {$urandom, $urandom}, {$urandom, $urandom});
      end
   endtask

   task automatic checkResetState();
      for (int d = 0; d < 2; d++) begin
         checkOutput("rst_req_ready", d, 64'(reqReady[d]), 64'h1);
         checkOutput("rst_rsp_valid", d, 64'(rspValid[d]), 64'h0);
         checkOutput("rst_rsp_rdata", d, rspRdata[d], 64'h0);
         checkOutput("rst_rsp_err", d, 64'(rspErr[d]), 64'h0);
         checkOutput("rst_mem_en", d, 64'(memEn[d]), 64'h0);
         checkOutput("rst_mem_we", d, 64'(memWe[d]), 64'h0);
         checkOutput("rst_mem_addr", d, 64'(memAddr[d]), 64'h0);
         checkOutput("rst_mem_wdata", d, memWdata[d], 64'h0);
      end
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog actual=running required=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst = 1'b1;
      for (int d = 0; d < 2; d++) begin
         reqValid[d] = 1'b0; reqWe[d] = 1'b0; reqCtrl[d] = '0; reqAddr[d] = '0;
         reqWdata[d] = '0; memRdata[d] = '0; rspReady[d] = 1'b1; ramWord[d] = '0;
         holdCnt[d] = 0; dueCnt[d] = 0; busy[d] = 1'b0;
      end
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checkResetState();
      @(posedge clk);
      #1;

      applyStimulus(0, 1'b1, 3'b011, 32'h0000_0003, 64'h0000_00A5, 64'h0);
      applyStimulus(0, 1'b0, 3'b001, 32'h0000_0002, 64'h0, 64'h8001_7F80);
      applyStimulus(0, 1'b0, 3'b010, 32'h0000_0002, 64'h0, 64'h8001_7F80);
      applyStimulus(0, 1'b0, 3'b011, 32'h0000_0000, 64'h0, 64'h8001_7F80);
      applyStimulus(0, 1'b0, 3'b000, 32'h0000_0006, 64'h0, 64'h1234_5678);
      applyStimulus(0, 1'b0, 3'b110, 32'h0000_0000, 64'h0, 64'h1234_5678);
      applyStimulus(0, 1'b1, 3'b001, 32'h0000_0012, 64'hBEEF, 64'h0);

      waitIdle(0);
      holdCnt[0] = 10;
      applyStimulus(0, 1'b0, 3'b000, 32'h0000_0104, 64'h0, 64'hCAFE_F00D);

      waitIdle(0);
      applyStimulus(0, 1'b0, 3'b000, 32'h0000_0008, 64'h0, 64'hDEAD_BEEF);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checkResetState();
      repeat (6) @(posedge clk);
      #1;

      randomTraffic(0, 40);
      waitIdle(0);

      applyStimulus(1, 1'b1, 3'b110, 32'h0000_0008, 64'h0123_4567_89AB_CDEF, 64'h0);
      applyStimulus(1, 1'b0, 3'b101, 32'h0000_0004, 64'h0, 64'h8000_0000_0000_0000);
      applyStimulus(1, 1'b0, 3'b000, 32'h0000_0004, 64'h0, 64'h8000_0000_0000_0000);
      applyStimulus(1, 1'b1, 3'b001, 32'h0000_0006, 64'h0000_1234, 64'h0);
      applyStimulus(1, 1'b0, 3'b110, 32'h0000_0004, 64'h0, 64'h1);
      applyStimulus(1, 1'b0, 3'b111, 32'h0000_0000, 64'h0, 64'h1);
      randomTraffic(1, 40);
      waitIdle(1);

      repeat (3) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
